// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined RV32I control unit: opcode values,
// ALU-operation and write-back select encodings, and the control bundle.
package pipe_ctrl_pkg;

   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_TYPE = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BR     = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_BR  = 2'b01,
      ALU_R   = 2'b10,
      ALU_I   = 2'b11
   } aluop_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10,
      WB_IMM = 2'b11
   } wbsel_e;

   typedef struct packed {
      logic   alusrc;
      aluop_e aluop;
      logic   branch;
      logic   jump;
      logic   jalr;
      logic   memread;
      logic   memwrite;
      logic   regwrite;
      wbsel_e wbsel;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_NOP = '{
      alusrc:   1'b0,
      aluop:    ALU_ADD,
      branch:   1'b0,
      jump:     1'b0,
      jalr:     1'b0,
      memread:  1'b0,
      memwrite: 1'b0,
      regwrite: 1'b0,
      wbsel:    WB_ALU
   };

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// ID-stage opcode decoder: produces the control bundle, the destination
// register to carry forward, source-register usage flags and the illegal flag.
module ctrl_decode
   import pipe_ctrl_pkg::*;
#(
   parameter int OPC_W   = 7,
   parameter int RA_W    = 5,
   parameter int EN_JUMP = 1
) (
   input  logic             valid,
   input  logic [OPC_W-1:0] opcode,
   input  logic [RA_W-1:0]  rd,
   output ctrl_bundle_t     bundle,
   output logic [RA_W-1:0]  rd_out,
   output logic             use_rs1,
   output logic             use_rs2,
   output logic             illegal
);

   ctrl_bundle_t raw_s;
   logic         raw_use1_s;
   logic         raw_use2_s;
   logic         known_s;

   // Opcode lookup table, independent of the valid qualifier.
   always_comb begin
      raw_s      = CTRL_NOP;
      raw_use1_s = 1'b0;
      raw_use2_s = 1'b0;
      known_s    = 1'b1;
      case (opcode)
         R_TYPE: begin
            raw_s.aluop    = ALU_R;
            raw_s.regwrite = 1'b1;
            raw_use1_s     = 1'b1;
            raw_use2_s     = 1'b1;
         end
         I_TYPE: begin
            raw_s.alusrc   = 1'b1;
            raw_s.aluop    = ALU_I;
            raw_s.regwrite = 1'b1;
            raw_use1_s     = 1'b1;
         end
         LOAD: begin
            raw_s.alusrc   = 1'b1;
            raw_s.aluop    = ALU_ADD;
            raw_s.memread  = 1'b1;
            raw_s.regwrite = 1'b1;
            raw_s.wbsel    = WB_MEM;
            raw_use1_s     = 1'b1;
         end
         STORE: begin
            raw_s.alusrc   = 1'b1;
            raw_s.aluop    = ALU_ADD;
            raw_s.memwrite = 1'b1;
            raw_use1_s     = 1'b1;
            raw_use2_s     = 1'b1;
         end
         BR: begin
            raw_s.aluop    = ALU_BR;
            raw_s.branch   = 1'b1;
            raw_use1_s     = 1'b1;
            raw_use2_s     = 1'b1;
         end
         LUI: begin
            raw_s.alusrc   = 1'b1;
            raw_s.regwrite = 1'b1;
            raw_s.wbsel    = WB_IMM;
         end
         JAL: begin
            if (EN_JUMP != 0) begin
               raw_s.jump     = 1'b1;
               raw_s.regwrite = 1'b1;
               raw_s.wbsel    = WB_PC4;
            end else begin
               known_s = 1'b0;
            end
         end
         JALR: begin
            if (EN_JUMP != 0) begin
               raw_s.alusrc   = 1'b1;
               raw_s.jalr     = 1'b1;
               raw_s.regwrite = 1'b1;
               raw_s.wbsel    = WB_PC4;
               raw_use1_s     = 1'b1;
            end else begin
               known_s = 1'b0;
            end
         end
         default: begin
            known_s = 1'b0;
         end
      endcase
   end

   // Qualify with valid: empty or unknown slots become a NOP that reads no
   // registers, so they can never trigger a load-use stall.
   always_comb begin
      if (valid && known_s) begin
         bundle          = raw_s;
         bundle.regwrite = raw_s.regwrite & (rd != {RA_W{1'b0}});
         rd_out          = rd;
         use_rs1         = raw_use1_s;
         use_rs2         = raw_use2_s;
         illegal         = 1'b0;
      end else begin
         bundle          = CTRL_NOP;
         rd_out          = {RA_W{1'b0}};
         use_rs1         = 1'b0;
         use_rs2         = 1'b0;
         illegal         = valid;
      end
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes in ID, carries control through the
// ID/EX, EX/MEM and MEM/WB registers, and resolves load-use stalls and
// redirect flushes.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int OPC_W     = 7,
   parameter int RA_W      = 5,
   parameter int EN_JUMP   = 1,
   parameter int EN_HAZARD = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid_i,
   input  logic [OPC_W-1:0] id_opcode_i,
   input  logic [RA_W-1:0]  id_rs1_i,
   input  logic [RA_W-1:0]  id_rs2_i,
   input  logic [RA_W-1:0]  id_rd_i,
   input  logic             ex_redirect_i,
   output logic             stall_o,
   output logic             flush_ifid_o,
   output logic             illegal_o,
   output logic             ex_alusrc_o,
   output logic [1:0]       ex_aluop_o,
   output logic             ex_branch_o,
   output logic             ex_jump_o,
   output logic             ex_jalr_o,
   output logic             ex_memread_o,
   output logic [RA_W-1:0]  ex_rd_o,
   output logic             mem_memread_o,
   output logic             mem_memwrite_o,
   output logic             wb_regwrite_o,
   output logic [1:0]       wb_wbsel_o,
   output logic [RA_W-1:0]  wb_rd_o
);

   ctrl_bundle_t    id_bundle_s;
   logic [RA_W-1:0] id_rd_s;
   logic            use_rs1_s;
   logic            use_rs2_s;
   logic            hazard_s;
   logic            bubble_s;

   ctrl_bundle_t    ex_ctrl_r;
   logic [RA_W-1:0] ex_rd_r;
   ctrl_bundle_t    mem_ctrl_r;
   logic [RA_W-1:0] mem_rd_r;
   ctrl_bundle_t    wb_ctrl_r;
   logic [RA_W-1:0] wb_rd_r;

   ctrl_decode #(
      .OPC_W   (OPC_W),
      .RA_W    (RA_W),
      .EN_JUMP (EN_JUMP)
   ) u_decode (
      .valid   (id_valid_i),
      .opcode  (id_opcode_i),
      .rd      (id_rd_i),
      .bundle  (id_bundle_s),
      .rd_out  (id_rd_s),
      .use_rs1 (use_rs1_s),
      .use_rs2 (use_rs2_s),
      .illegal (illegal_o)
   );

   // Load-use detection: the load in EX writes a register the ID instruction reads.
   always_comb begin
      hazard_s = 1'b0;
      if ((EN_HAZARD != 0) && ex_ctrl_r.memread && (ex_rd_r != {RA_W{1'b0}})) begin
         hazard_s = (use_rs1_s && (id_rs1_i == ex_rd_r)) ||
                    (use_rs2_s && (id_rs2_i == ex_rd_r));
      end else begin
         hazard_s = 1'b0;
      end
   end

   // A redirect overrides the stall; either event injects a bubble into ID/EX.
   assign stall_o      = hazard_s & ~ex_redirect_i;
   assign flush_ifid_o = ex_redirect_i;
   assign bubble_s     = hazard_s | ex_redirect_i;

   // ID/EX stage register: decoded bundle or bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_ctrl_r <= CTRL_NOP;
         ex_rd_r   <= {RA_W{1'b0}};
      end else if (bubble_s) begin
         ex_ctrl_r <= CTRL_NOP;
         ex_rd_r   <= {RA_W{1'b0}};
      end else begin
         ex_ctrl_r <= id_bundle_s;
         ex_rd_r   <= id_rd_s;
      end
   end

   // EX/MEM stage register: always advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ctrl_r <= CTRL_NOP;
         mem_rd_r   <= {RA_W{1'b0}};
      end else begin
         mem_ctrl_r <= ex_ctrl_r;
         mem_rd_r   <= ex_rd_r;
      end
   end

   // MEM/WB stage register: always advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ctrl_r <= CTRL_NOP;
         wb_rd_r   <= {RA_W{1'b0}};
      end else begin
         wb_ctrl_r <= mem_ctrl_r;
         wb_rd_r   <= mem_rd_r;
      end
   end

   assign ex_alusrc_o    = ex_ctrl_r.alusrc;
   assign ex_aluop_o     = ex_ctrl_r.aluop;
   assign ex_branch_o    = ex_ctrl_r.branch;
   assign ex_jump_o      = ex_ctrl_r.jump;
   assign ex_jalr_o      = ex_ctrl_r.jalr;
   assign ex_memread_o   = ex_ctrl_r.memread;
   assign ex_rd_o        = ex_rd_r;
   assign mem_memread_o  = mem_ctrl_r.memread;
   assign mem_memwrite_o = mem_ctrl_r.memwrite;
   assign wb_regwrite_o  = wb_ctrl_r.regwrite;
   assign wb_wbsel_o     = wb_ctrl_r.wbsel;
   assign wb_rd_o        = wb_rd_r;

endmodule
